// File: rtl/riscv_pkg.sv
// RV32I encoding constants and ALU control codes shared by the ALU decoder and the instruction encoder.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_ctrl_e;

  localparam logic [3:0] ALU_CODE_MAX = 4'b1001;

  typedef enum logic [1:0] {
    KIND_R   = 2'b00,
    KIND_I   = 2'b01,
    KIND_BR  = 2'b10,
    KIND_RSV = 2'b11
  } kind_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    kind_e       kind;
    logic [3:0]  alu_ctrl;
    logic [2:0]  br_funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
  } enc_req_t;

  // funct3 shared by the R-type and I-type forms of each ALU operation
  function automatic logic [2:0] alu_funct3(input logic [3:0] ctrl);
    logic [2:0] f3;
    f3 = F3_ADD_SUB;
    case (ctrl)
      ALU_ADD, ALU_SUB: f3 = F3_ADD_SUB;
      ALU_SLL:          f3 = F3_SLL;
      ALU_SLT:          f3 = F3_SLT;
      ALU_SLTU:         f3 = F3_SLTU;
      ALU_XOR:          f3 = F3_XOR;
      ALU_SRL, ALU_SRA: f3 = F3_SRL_SRA;
      ALU_OR:           f3 = F3_OR;
      ALU_AND:          f3 = F3_AND;
      default:          f3 = F3_ADD_SUB;
    endcase
    return f3;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// DEPTH x WIDTH synchronous FIFO whose head word is held in a register, so the read port
// has no combinational path from the write port.
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_n;
  logic [LW-1:0]    level_n;
  logic             push_ok;
  logic             pop_ok;
  logic [WIDTH-1:0] head_n;

  // Next head: the word being written wins when it lands in the new head slot
  always_comb begin
    push_ok  = push && (level != LW'(DEPTH));
    pop_ok   = pop && (level != '0);
    rd_ptr_n = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
    level_n  = level + LW'(push_ok) - LW'(pop_ok);
    head_n   = (push_ok && (wr_ptr == rd_ptr_n)) ? wdata : mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Head register keeps its last value while the FIFO is empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rdata  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_n;
      level  <= level_n;
      if (level_n != '0) rdata <= head_n;
    end
  end

endmodule

// File: rtl/alu_instr_encoder.sv
// Encodes ALU/branch requests into RV32I instruction words, buffers them and tags each
// output word with its byte address.
module alu_instr_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_kind,
  input  logic [3:0]             in_alu_ctrl,
  input  logic [2:0]             in_br_funct3,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [12:0]            in_imm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_addr,
  output logic                   illegal,
  output logic [7:0]             err_count,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  enc_req_t    req;
  logic        accept;
  logic        legal;
  logic        push;
  logic        pop;
  logic [31:0] instr;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        is_shift;
  logic        ctrl_ok;

  assign req = '{kind:      kind_e'(in_kind),
                 alu_ctrl:  in_alu_ctrl,
                 br_funct3: in_br_funct3,
                 rd:        in_rd,
                 rs1:       in_rs1,
                 rs2:       in_rs2,
                 imm:       in_imm};

  assign in_ready  = level < LW'(DEPTH);
  assign out_valid = level != '0;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = out_valid && out_ready;

  // Field assembly and legality check for one request
  always_comb begin
    f3       = alu_funct3(req.alu_ctrl);
    f7       = ((req.alu_ctrl == ALU_SUB) || (req.alu_ctrl == ALU_SRA)) ? F7_ALT : F7_BASE;
    is_shift = req.alu_ctrl inside {ALU_SLL, ALU_SRL, ALU_SRA};
    ctrl_ok  = req.alu_ctrl <= ALU_CODE_MAX;
    legal    = 1'b0;
    instr    = '0;
    case (req.kind)
      KIND_R: begin
        legal = ctrl_ok;
        instr = {f7, req.rs2, req.rs1, f3, req.rd, OPC_OP};
      end
      KIND_I: begin
        legal = ctrl_ok && (req.alu_ctrl != ALU_SUB);
        if (is_shift) instr = {f7, req.imm[4:0], req.rs1, f3, req.rd, OPC_OP_IMM};
        else          instr = {req.imm[11:0], req.rs1, f3, req.rd, OPC_OP_IMM};
      end
      KIND_BR: begin
        legal = !((req.br_funct3 == 3'b010) || (req.br_funct3 == 3'b011)) && !req.imm[0];
        instr = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.br_funct3,
                 req.imm[4:1], req.imm[11], OPC_BRANCH};
      end
      default: legal = 1'b0;
    endcase
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (instr),
    .pop   (pop),
    .rdata (out_instr),
    .level (level)
  );

  // Address of the head word advances only on a completed pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_addr  <= BASE_ADDR;
      illegal   <= 1'b0;
      err_count <= '0;
    end else begin
      if (pop) out_addr <= out_addr + 32'd4;
      illegal <= accept && !legal;
      if (accept && !legal && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_instr_encoder.sv
// Randomized scoreboard bench for alu_instr_encoder against a field-arithmetic reference model.
module tb_alu_instr_encoder;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_kind = '0;
  logic [3:0]  in_alu_ctrl = '0;
  logic [2:0]  in_br_funct3 = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [12:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        illegal;
  logic [7:0]  err_count;
  logic [2:0]  level;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] npop = 0;
  logic [31:0] errm = 0;
  logic        rand_on = 1'b0;
  logic [31:0] f3tab [10] = '{0, 0, 7, 6, 4, 2, 3, 1, 5, 5};

  alu_instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_alu_ctrl(in_alu_ctrl), .in_br_funct3(in_br_funct3),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .illegal(illegal), .err_count(err_count), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: instruction word built by shifting and adding fields
  function automatic void model(input logic [31:0] kind, input logic [31:0] ctrl,
                                input logic [31:0] f3b, input logic [31:0] rd,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm, output logic legal,
                                output logic [31:0] w);
    logic [31:0] alt;
    logic [31:0] f3;
    logic        shift;
    alt   = (ctrl == 1 || ctrl == 9) ? 32'h4000_0000 : 32'h0;
    f3    = (ctrl < 10) ? f3tab[ctrl] : 32'h0;
    shift = (ctrl >= 7) && (ctrl <= 9);
    legal = 1'b0;
    w     = 32'h0;
    case (kind)
      0: begin
        legal = ctrl < 10;
        w = alt | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      end
      1: begin
        legal = (ctrl < 10) && (ctrl != 1);
        if (shift) w = alt | ((imm & 32'h1f) << 20);
        else       w = (imm & 32'hfff) << 20;
        w = w | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
      end
      2: begin
        legal = (f3b != 2) && (f3b != 3) && ((imm & 1) == 0);
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20) |
            (rs1 << 15) | (f3b << 12) | (((imm >> 1) & 15) << 8) |
            (((imm >> 11) & 1) << 7) | 32'h63;
      end
      default: legal = 1'b0;
    endcase
  endfunction

  // Drive one request until accepted; enqueue the expectation after the accepting edge
  task automatic send(input logic [31:0] kind, input logic [31:0] ctrl, input logic [31:0] f3b,
                      input logic [31:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] imm);
    logic        legal;
    logic [31:0] w;
    int          n;
    model(kind, ctrl, f3b, rd, rs1, rs2, imm, legal, w);
    in_kind      = 2'(kind);
    in_alu_ctrl  = 4'(ctrl);
    in_br_funct3 = 3'(f3b);
    in_rd        = 5'(rd);
    in_rs1       = 5'(rs1);
    in_rs2       = 5'(rs2);
    in_imm       = 13'(imm);
    in_valid     = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      chk("send_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (legal) exp_q.push_back(w);
      else if (errm != 255) errm++;
      chk("illegal", 32'(illegal), 32'(!legal));
      chk("err_count", 32'(err_count), errm);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, BASE);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: compares the head word and occupancy against the scoreboard every cycle
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("level", 32'(level), 32'(exp_q.size()));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
      if (out_valid && exp_q.size() != 0) begin
        chk("out_instr", out_instr, exp_q[0]);
        chk("out_addr", out_addr, BASE + 32'd4 * npop);
        if (out_ready) begin
          void'(exp_q.pop_front());
          npop++;
        end
      end
    end
  end

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b0;

    // Directed words with known encodings
    out_ready = 1'b1;
    send(0, 1, 0, 3, 1, 2, 0);
    chk("sub_word", out_instr, 32'h402081B3);
    chk("sub_addr", out_addr, BASE);
    send(1, 0, 0, 1, 0, 0, 5);
    chk("addi_word", out_instr, 32'h00500093);
    send(1, 9, 0, 5, 5, 0, 3);
    chk("srai_word", out_instr, 32'h4032D293);
    chk("srai_addr", out_addr, BASE + 32'd8);
    send(2, 0, 0, 0, 1, 2, 8);
    chk("beq_word", out_instr, 32'h00208463);
    send(2, 0, 0, 0, 1, 2, 9);
    chk("beq_odd_err", 32'(err_count), 32'd1);
    drain();

    // Backpressure: fifth request stalls until the consumer resumes
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 32'(i), 0, 32'(i + 1), 32'(i + 2), 32'(i + 3), 0);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_level", 32'(level), 32'd4);
    fork
      send(1, 3, 0, 7, 8, 0, 32'h7ff);
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("bp_stall_level", 32'(level), 32'd4);
        out_ready = 1'b1;
      end
    join
    drain();

    // Concurrent push and pop with two words in flight
    out_ready = 1'b0;
    send(0, 2, 0, 1, 1, 1, 0);
    send(0, 3, 0, 2, 2, 2, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(0, 32'($urandom_range(0, 9)), 0, 32'($urandom_range(0, 31)),
           32'($urandom_range(0, 31)), 32'($urandom_range(0, 31)), 0);
      chk("steady_level", 32'(level), 32'd2);
    end
    drain();

    // Error counter saturation
    for (int i = 0; i < 300; i++)
      send(3, 32'($urandom_range(0, 15)), 32'($urandom_range(0, 7)), 1, 2, 3,
           32'($urandom_range(0, 8191)));
    chk("err_saturated", 32'(err_count), 32'd255);

    // Reset with three words queued and an illegal pulse pending
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(0, 0, 0, 32'(i), 1, 1, 0);
    send(1, 1, 0, 1, 1, 0, 0);
    chk("pre_reset_level", 32'(level), 32'd3);
    #2 reset = 1'b1;
    #1;
    check_reset_vals();
    exp_q.delete();
    npop = 0;
    errm = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    send(0, 4, 0, 9, 10, 11, 0);
    chk("post_reset_addr", out_addr, BASE);
    drain();

    // Randomized traffic with random consumer stalls
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [31:0] k;
          logic [31:0] imm;
          k   = 32'($urandom_range(0, 3));
          imm = 32'($urandom_range(0, 8191));
          if (k == 2 && $urandom_range(0, 3) != 0) imm = imm & 32'h1ffe;
          send(k, (k == 2) ? 32'($urandom_range(0, 9)) : 32'($urandom_range(0, 15)),
               32'($urandom_range(0, 7)), 32'($urandom_range(0, 31)),
               32'($urandom_range(0, 31)), 32'($urandom_range(0, 31)), imm);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
